// File: rtl/vpu_ub_writeback.sv
// Deskews the two VPU result lanes through per-lane FIFOs and writes paired rows
// into the unified buffer with an auto-incrementing address.
module vpu_ub_writeback #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_in,
    input  logic [ADDR_W-1:0] base_addr_in,
    input  logic [ADDR_W-1:0] num_rows_in,
    input  logic [DATA_W-1:0] lane_1_data_in,
    input  logic              lane_1_valid_in,
    input  logic [DATA_W-1:0] lane_2_data_in,
    input  logic              lane_2_valid_in,
    input  logic              ub_wr_ready_in,
    output logic              ub_wr_en_out,
    output logic [ADDR_W-1:0] ub_wr_addr_out,
    output logic [DATA_W-1:0] ub_wr_data_1_out,
    output logic [DATA_W-1:0] ub_wr_data_2_out,
    output logic              busy_out,
    output logic              done_out,
    output logic              overflow_out
);
    // state   | meaning
    // IDLE    | waiting for start_in; lane beats ignored
    // COLLECT | lanes pushed into FIFOs, rows issued to the UB
    // DONE    | single-cycle done_out pulse, then back to IDLE
    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DONE} state_t;

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    state_t            state;
    logic [DATA_W-1:0] mem [2][FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr [2];
    logic [PTR_W-1:0]  rd_ptr [2];
    logic [CNT_W-1:0]  cnt [2];
    logic [DATA_W-1:0] lane_data [2];
    logic [ADDR_W-1:0] base_addr, num_rows, issued, accepted;
    logic [1:0]        lane_valid, push_req, push_ok, fifo_empty, fifo_full;
    logic              load, accept, last_accept, drop;

    assign lane_valid   = {lane_2_valid_in, lane_1_valid_in};
    assign lane_data[0] = lane_1_data_in;
    assign lane_data[1] = lane_2_data_in;
    assign fifo_empty   = {cnt[1] == '0, cnt[0] == '0};
    assign fifo_full    = {cnt[1] == CNT_W'(FIFO_DEPTH), cnt[0] == CNT_W'(FIFO_DEPTH)};

    always_comb begin
        load = (state == S_COLLECT) && (fifo_empty == 2'b00) && (issued < num_rows)
               && (!ub_wr_en_out || ub_wr_ready_in);
        push_req = (state == S_COLLECT) ? lane_valid : 2'b00;
        // A full FIFO still takes the beat when the head leaves on the same edge.
        push_ok     = push_req & (~fifo_full | {2{load}});
        drop        = |(push_req & ~push_ok);
        accept      = ub_wr_en_out && ub_wr_ready_in;
        last_accept = accept && ((accepted + 1'b1) == num_rows);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= S_IDLE;
            base_addr        <= '0;
            num_rows         <= '0;
            issued           <= '0;
            accepted         <= '0;
            ub_wr_en_out     <= 1'b0;
            ub_wr_addr_out   <= '0;
            ub_wr_data_1_out <= '0;
            ub_wr_data_2_out <= '0;
            busy_out         <= 1'b0;
            done_out         <= 1'b0;
            overflow_out     <= 1'b0;
            for (int k = 0; k < 2; k++) begin
                wr_ptr[k] <= '0;
                rd_ptr[k] <= '0;
                cnt[k]    <= '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (push_ok[k]) begin
                    mem[k][wr_ptr[k]] <= lane_data[k];
                    wr_ptr[k]         <= wr_ptr[k] + 1'b1;
                end
                if (load) rd_ptr[k] <= rd_ptr[k] + 1'b1;
                case ({push_ok[k], load})
                    2'b10:   cnt[k] <= cnt[k] + 1'b1;
                    2'b01:   cnt[k] <= cnt[k] - 1'b1;
                    default: ;
                endcase
            end

            if (load) begin
                ub_wr_en_out     <= 1'b1;
                ub_wr_addr_out   <= base_addr + issued;
                ub_wr_data_1_out <= mem[0][rd_ptr[0]];
                ub_wr_data_2_out <= mem[1][rd_ptr[1]];
                issued           <= issued + 1'b1;
            end else if (accept) begin
                ub_wr_en_out <= 1'b0;
            end

            if (accept) accepted <= accepted + 1'b1;
            if (drop) overflow_out <= 1'b1;
            done_out <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start_in) begin
                        base_addr    <= base_addr_in;
                        num_rows     <= num_rows_in;
                        issued       <= '0;
                        accepted     <= '0;
                        overflow_out <= 1'b0;
                        for (int k = 0; k < 2; k++) begin
                            wr_ptr[k] <= '0;
                            rd_ptr[k] <= '0;
                            cnt[k]    <= '0;
                        end
                        if (num_rows_in == '0) begin
                            state    <= S_DONE;
                            done_out <= 1'b1;
                        end else begin
                            state    <= S_COLLECT;
                            busy_out <= 1'b1;
                        end
                    end
                end
                S_COLLECT: begin
                    if (last_accept) begin
                        state    <= S_DONE;
                        busy_out <= 1'b0;
                        done_out <= 1'b1;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vpu_ub_writeback.sv
// Scoreboard bench for vpu_ub_writeback: directed jobs push expected UB writes,
// a negedge monitor pops and compares every accepted write.
module tb_vpu_ub_writeback;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              start_in;
    logic [ADDR_W-1:0] base_addr_in, num_rows_in;
    logic [DATA_W-1:0] lane_1_data_in, lane_2_data_in;
    logic              lane_1_valid_in, lane_2_valid_in;
    logic              ub_wr_ready_in;
    logic              ub_wr_en_out;
    logic [ADDR_W-1:0] ub_wr_addr_out;
    logic [DATA_W-1:0] ub_wr_data_1_out, ub_wr_data_2_out;
    logic              busy_out, done_out, overflow_out;

    vpu_ub_writeback #(.DATA_W(DATA_W), .FIFO_DEPTH(4), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .start_in(start_in),
        .base_addr_in(base_addr_in), .num_rows_in(num_rows_in),
        .lane_1_data_in(lane_1_data_in), .lane_1_valid_in(lane_1_valid_in),
        .lane_2_data_in(lane_2_data_in), .lane_2_valid_in(lane_2_valid_in),
        .ub_wr_ready_in(ub_wr_ready_in), .ub_wr_en_out(ub_wr_en_out),
        .ub_wr_addr_out(ub_wr_addr_out), .ub_wr_data_1_out(ub_wr_data_1_out),
        .ub_wr_data_2_out(ub_wr_data_2_out), .busy_out(busy_out),
        .done_out(done_out), .overflow_out(overflow_out)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          start_cyc = 0;
    logic [39:0] exp_q[$];
    int          acc_cyc[$];
    logic [39:0] mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (ub_wr_en_out && ub_wr_ready_in) begin
                acc_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_write: got addr %0h data %0h/%0h expected none",
                             ub_wr_addr_out, ub_wr_data_1_out, ub_wr_data_2_out);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("ub_write", {ub_wr_addr_out, ub_wr_data_1_out, ub_wr_data_2_out}, mon_e);
                end
            end
            if (done_out) begin
                done_cnt++;
                check("busy_at_done", busy_out, 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_push(input logic [7:0] a, input logic [15:0] d1, input logic [15:0] d2);
        exp_q.push_back({a, d1, d2});
    endtask

    task automatic start_job(input logic [7:0] base, input logic [7:0] rows);
        start_in     = 1'b1;
        base_addr_in = base;
        num_rows_in  = rows;
        tick();
        start_in  = 1'b0;
        acc_cyc.delete();
        start_cyc = cyc;
    endtask

    task automatic beat(input logic v1, input logic [15:0] d1, input logic v2, input logic [15:0] d2);
        lane_1_valid_in = v1;
        lane_1_data_in  = d1;
        lane_2_valid_in = v2;
        lane_2_data_in  = d2;
        tick();
        lane_1_valid_in = 1'b0;
        lane_2_valid_in = 1'b0;
    endtask

    task automatic end_job(input string name);
        int d0;
        int i;
        d0 = done_cnt;
        for (i = 0; i < 50 && done_cnt == d0; i++) tick();
        if (done_cnt == d0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_done_timeout: got no done pulse expected one within 50 cycles", name);
        end
        repeat (3) tick();
        check({name, "_done_once"}, done_cnt - d0, 1);
        check({name, "_rows_left"}, exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start_in = 1'b0; base_addr_in = '0; num_rows_in = '0;
        lane_1_data_in = '0; lane_2_data_in = '0;
        lane_1_valid_in = 1'b0; lane_2_valid_in = 1'b0; ub_wr_ready_in = 1'b1;
        repeat (2) tick();
        check("reset_outputs", {ub_wr_en_out, ub_wr_addr_out, ub_wr_data_1_out, ub_wr_data_2_out,
                                busy_out, done_out, overflow_out}, 0);
        rst = 1'b0;
        tick();

        // 1: skewed lanes, ready always high
        exp_push(8'h10, 16'h0A01, 16'h0D04);
        exp_push(8'h11, 16'h0B02, 16'h0E05);
        exp_push(8'h12, 16'h0C03, 16'h0F06);
        start_job(8'h10, 8'd3);
        check("t1_busy", busy_out, 1);
        beat(1, 16'h0A01, 0, 16'h0);
        beat(1, 16'h0B02, 1, 16'h0D04);
        beat(1, 16'h0C03, 1, 16'h0E05);
        beat(0, 16'h0, 1, 16'h0F06);
        end_job("t1");
        check("t1_accepts", acc_cyc.size(), 3);
        if (acc_cyc.size() == 3) begin
            check("t1_latency", acc_cyc[0] - start_cyc, 3);
            check("t1_back_to_back", acc_cyc[2] - acc_cyc[0], 2);
        end

        // 2: backpressure on the first write
        ub_wr_ready_in = 1'b0;
        exp_push(8'h10, 16'h0A01, 16'h0D04);
        exp_push(8'h11, 16'h0B02, 16'h0E05);
        exp_push(8'h12, 16'h0C03, 16'h0F06);
        start_job(8'h10, 8'd3);
        beat(1, 16'h0A01, 0, 16'h0);
        beat(1, 16'h0B02, 1, 16'h0D04);
        beat(1, 16'h0C03, 1, 16'h0E05);
        beat(0, 16'h0, 1, 16'h0F06);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t2_hold", {ub_wr_en_out, ub_wr_addr_out, ub_wr_data_1_out, ub_wr_data_2_out},
                  {1'b1, 8'h10, 16'h0A01, 16'h0D04});
        end
        ub_wr_ready_in = 1'b1;
        end_job("t2");
        check("t2_no_overflow", overflow_out, 0);

        // 3: lane 1 overruns its FIFO while lane 2 is silent
        for (int i = 1; i <= 4; i++) exp_push(8'h3F + 8'(i), 16'(i), 16'(i + 6));
        start_job(8'h40, 8'd4);
        for (int i = 1; i <= 6; i++) begin
            beat(1, 16'(i), 0, 16'h0);
            if (i == 4) check("t3_ovf_before", overflow_out, 0);
            if (i == 5) check("t3_ovf_after", overflow_out, 1);
        end
        for (int i = 7; i <= 10; i++) beat(0, 16'h0, 1, 16'(i));
        end_job("t3");
        check("t3_ovf_sticky", overflow_out, 1);

        // 4: address roll-over
        exp_push(8'hFE, 16'h0011, 16'h0021);
        exp_push(8'hFF, 16'h0012, 16'h0022);
        exp_push(8'h00, 16'h0013, 16'h0023);
        start_job(8'hFE, 8'd3);
        check("t4_ovf_cleared", overflow_out, 0);
        beat(1, 16'h0011, 1, 16'h0021);
        beat(1, 16'h0012, 1, 16'h0022);
        beat(1, 16'h0013, 1, 16'h0023);
        end_job("t4");

        // 5a: zero-row job
        start_job(8'h55, 8'd0);
        check("t5_zero_done", {done_out, busy_out, ub_wr_en_out}, 3'b100);
        tick();
        check("t5_zero_after", {done_out, busy_out, ub_wr_en_out}, 3'b000);

        // 5b: start while busy is ignored
        exp_push(8'h30, 16'h0031, 16'h0041);
        exp_push(8'h31, 16'h0032, 16'h0042);
        start_job(8'h30, 8'd2);
        start_in = 1'b1; base_addr_in = 8'h80; num_rows_in = 8'd5;
        tick();
        start_in = 1'b0;
        check("t5_busy_kept", busy_out, 1);
        beat(1, 16'h0031, 1, 16'h0041);
        beat(1, 16'h0032, 1, 16'h0042);
        end_job("t5b");

        // 6: reset after one of three rows accepted
        exp_push(8'h50, 16'h0061, 16'h0071);
        start_job(8'h50, 8'd3);
        beat(1, 16'h0061, 1, 16'h0071);
        beat(1, 16'h0099, 0, 16'h0);
        tick();
        begin
            int d0;
            d0  = done_cnt;
            rst = 1'b1;
            tick();
            check("t6_reset_outputs", {ub_wr_en_out, ub_wr_addr_out, ub_wr_data_1_out,
                                       ub_wr_data_2_out, busy_out, done_out, overflow_out}, 0);
            tick();
            rst = 1'b0;
            tick();
            check("t6_no_done", done_cnt - d0, 0);
        end
        check("t6_row1_seen", exp_q.size(), 0);
        exp_push(8'h20, 16'h0077, 16'h0088);
        start_job(8'h20, 8'd1);
        beat(1, 16'h0077, 1, 16'h0088);
        end_job("t6");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/vpu_ub_writeback.md
Name: vpu_ub_writeback

Overview:
- Downstream neighbour of the VPU: consumes the two per-column result lanes (data or final-H), deskews them and writes complete rows into the unified buffer (UB).
- Lane 2 leaves the systolic array/VPU one or more cycles after lane 1, so each lane has its own small FIFO.
- Pairs the two lane heads into one UB row write with valid/ready handshake and an auto-incrementing address.
- Reports busy, done and overflow to the top-level controller.

Parameters:
DATA_W, 16, lane data width (Q8.8 fixed point, passed through unmodified)
FIFO_DEPTH, 4, entries per lane FIFO (power of two, >=2)
ADDR_W, 8, UB row address width

Ports:
clk  in  1  clock
rst  in  1  reset
start_in  in  1  pulse; begins a writeback job
base_addr_in  in  ADDR_W  first UB row address, latched on start
num_rows_in  in  ADDR_W  rows in job, latched on start
lane_1_data_in  in  DATA_W  VPU lane 1 data
lane_1_valid_in  in  1  lane 1 beat valid
lane_2_data_in  in  DATA_W  VPU lane 2 data
lane_2_valid_in  in  1  lane 2 beat valid
ub_wr_ready_in  in  1  UB accepts write this cycle
ub_wr_en_out  out  1  write request
ub_wr_addr_out  out  ADDR_W  row address
ub_wr_data_1_out  out  DATA_W  column 1 word
ub_wr_data_2_out  out  DATA_W  column 2 word
busy_out  out  1  job in progress
done_out  out  1  one-cycle pulse at job end
overflow_out  out  1  sticky; a lane beat was dropped

Behaviour:
- Reset: rst is synchronous, active-high. It clears all outputs to 0, empties both FIFOs, zeroes the row counter and sets the state to IDLE. Reset mid-job aborts the job with no done pulse.
- States:
  - IDLE: lane inputs are ignored and not pushed. start_in latches base/num_rows, clears the counter and overflow, and flushes both FIFOs. Next state is DONE if num_rows_in==0, else COLLECT.
  - COLLECT: lane beats are pushed into their FIFOs. start_in is ignored.
  - DONE: one cycle with done_out=1 and busy_out=0, then IDLE.
- busy_out=1 exactly while in COLLECT.
- Push rule: lane_k_valid_in=1 pushes lane_k_data_in at the clock edge. A push to a full FIFO is dropped and sets overflow_out, unless that FIFO pops in the same cycle, in which case the push succeeds.
- Output register: ub_wr_* is a registered skid-free output stage. It loads when all of the following hold:
  - state is COLLECT;
  - both FIFOs are non-empty;
  - issued rows < num_rows;
  - (ub_wr_en_out==0 or ub_wr_ready_in==1).
- Load action: pops one entry from each FIFO, sets ub_wr_en_out=1, drives addr = base + issued (mod 2^ADDR_W) and increments issued.
- Hold rule: while ub_wr_en_out=1 and ub_wr_ready_in=0, addr and data are held stable.
- Drop rule: on ub_wr_ready_in=1 with no new load, ub_wr_en_out drops to 0.
- Latency: a pair whose later beat is pushed at edge N drives ub_wr_en_out=1 after edge N+1 (2 edges), given ready and an empty path. At ready=1 the sustained throughput is 1 row/cycle.
- Completion: accepted rows are counted on ub_wr_en_out & ub_wr_ready_in. When accepted == num_rows, the next state is DONE. Beats arriving after the last issued row stay in the FIFOs and are flushed on the next start.
- Address wrap: the 0xFF→0x00 roll-over (ADDR_W=8) is legal and silent.
- Unequal beats on the two lanes leave residue in the FIFOs. This is not an error; only a full-FIFO drop sets overflow.

Test Plan:
1. Skewed lanes: start base=0x10 rows=3, ready=1. Lane 1 sends A,B,C on cycles 0-2; lane 2 sends D,E,F on cycles 1-3. Required: writes (0x10,A,D), (0x11,B,E), (0x12,C,F) on consecutive cycles; done_out pulses once; busy falls with done.
2. Backpressure: as test 1 but ready=0 for 3 cycles while the first write is pending. Required: addr=0x10 and data A/D held unchanged; all three rows still written in order; no overflow.
3. Overflow: rows=4, lane 1 sends 6 beats (1..6), lane 2 silent, then lane 2 sends 4 beats (7..10). Required: overflow_out=1 from the 5th lane 1 push onward; rows written are (1,7),(2,8),(3,9),(4,10).
4. Wrap: base=0xFE, rows=3, with matching lane beats. Required: addresses 0xFE, 0xFF, 0x00, then done.
5. Edge cases:
   - rows=0: done_out pulses the cycle after start, no ub_wr_en.
   - start asserted while busy: ignored; job continues unchanged.
6. Reset mid-job: assert rst after 1 of 3 rows is accepted. Required next cycle: all outputs 0, no done pulse. A new start with base=0x20 writes from 0x20 with no stale FIFO data.
